// File: rtl/stream_sched_pkg.sv
// Shared types and defaults for the stream scheduler.
// State encodings and default word/counter widths.
package stream_sched_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNTW_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    FLUSH,
    REPORT
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// pointer=1 gives requester 1 priority on contention.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic enable,
  input  logic pointer,
  output logic gnt0,
  output logic gnt1
);
  assign gnt0 = enable & req0 & (~req1 | ~pointer);
  assign gnt1 = enable & req1 & (~req0 | pointer);
endmodule

// File: rtl/stream_sched.sv
// Arbitrates two word sources, serializes the winner MSB first
// to an external detector and reports its hit count.
module stream_sched
  import stream_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             w_out,
  output logic             det_rst,
  input  logic             det_in,
  output logic             done,
  output logic             done_id,
  output logic [CNTW-1:0]  hit_cnt
);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CNTW-1:0]  bitcnt;
  logic [CNTW-1:0]  cnt;
  logic             ptr;
  logic             cur_id;
  logic             take;
  logic             sample;
  logic             enable;

  assign enable = (state == IDLE) & ~reset;
  assign take   = gnt0 | gnt1;

  rr_arb2 u_arb (
    .req0    (req0),
    .req1    (req1),
    .enable  (enable),
    .pointer (ptr),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  always_comb begin
    state_nx = state;
    w_out    = 1'b0;
    det_rst  = 1'b0;
    done     = 1'b0;
    sample   = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) state_nx = CLR;
      end
      CLR: begin
        det_rst  = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        w_out  = shreg[WIDTH-1];
        // det_in in shift cycle 0 still reflects the cleared detector
        sample = (bitcnt != '0);
        if (bitcnt == LAST) state_nx = FLUSH;
      end
      FLUSH: begin
        sample   = 1'b1;
        state_nx = REPORT;
      end
      REPORT: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      cnt     <= '0;
      ptr     <= 1'b0;
      cur_id  <= 1'b0;
      hit_cnt <= '0;
      done_id <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        shreg  <= gnt1 ? data1 : data0;
        cur_id <= gnt1;
        ptr    <= gnt0;
        cnt    <= '0;
        bitcnt <= '0;
      end
      if (state == SHIFT) begin
        shreg  <= {shreg[WIDTH-2:0], 1'b0};
        bitcnt <= bitcnt + 1'b1;
      end
      if (sample && det_in) cnt <= cnt + 1'b1;
      if (state == FLUSH) begin
        hit_cnt <= cnt + CNTW'(det_in);
        done_id <= cur_id;
      end
    end
  end
endmodule

// File: tb/tb_stream_sched.sv
// Bench for stream_sched: vector table, scoreboard and
// hand-written contention/busy/reset sequences.
module tb_stream_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, w_out, det_rst, det_in, done, done_id;
  logic [3:0] hit_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit id;
    int hit;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit         id;
    logic [7:0] d;
    bit         chg;
    logic [7:0] alt;
    int         hit;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  stream_sched #(.WIDTH(8), .CNTW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .data0   (data0),
    .req1    (req1),
    .data1   (data1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .w_out   (w_out),
    .det_rst (det_rst),
    .det_in  (det_in),
    .done    (done),
    .done_id (done_id),
    .hit_cnt (hit_cnt)
  );

  // detector: w_out delayed one register
  always @(posedge clk) begin
    if (reset || det_rst) det_in <= 1'b0;
    else det_in <= w_out;
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (reset) sb.delete();
    else begin
      if (gnt0 | gnt1) chk("gnt_onehot", int'(gnt0 & gnt1), 0);
      if (gnt0) sb.push_back('{1'b0, $countones(data0)});
      if (gnt1) sb.push_back('{1'b1, $countones(data1)});
      if (done) begin
        if (sb.size() == 0) chk("sb_unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_id", int'(done_id), int'(e.id));
          chk("sb_hit", int'(hit_cnt), e.hit);
        end
      end
    end
  end

  task automatic wait_idle();
    int c;
    for (c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
    chk("wait_idle_timeout", int'(c >= 40), 0);
  endtask

  task automatic run_word(input bit id, input logic [7:0] d,
                          input bit chg, input logic [7:0] alt,
                          input int exp_hit);
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; data1 = d; end
    else begin req0 = 1'b1; data0 = d; end
    @(negedge clk);
    chk("w_gnt", int'(id ? gnt1 : gnt0), 1);
    chk("w_gnt_other", int'(id ? gnt0 : gnt1), 0);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
        if (chg) begin data0 = alt; data1 = alt; end
      end
      @(negedge clk);
      if (c == 1) begin
        chk("w_det_rst", int'(det_rst), 1);
        chk("w_clr_out", int'(w_out), 0);
      end else if (c <= 9) begin
        chk("w_bit", int'(w_out), int'(d[9-c]));
        chk("w_nodone", int'(done), 0);
      end else if (c == 10) begin
        chk("w_flush_out", int'(w_out), 0);
        chk("w_flush_done", int'(done), 0);
      end else begin
        chk("w_done", int'(done), 1);
        chk("w_hit", int'(hit_cnt), exp_hit);
        chk("w_id", int'(done_id), int'(id));
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, last, nd;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
    tbl[0] = '{1'b0, 8'hB5, 1'b0, 8'h00, 5};
    tbl[1] = '{1'b1, 8'h3C, 1'b0, 8'h00, 4};
    tbl[2] = '{1'b0, 8'h81, 1'b1, 8'h00, 2};
    tbl[3] = '{1'b1, 8'hFF, 1'b1, 8'h00, 8};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 8'hFF, 0};
    tbl[5] = '{1'b1, 8'h01, 1'b0, 8'h00, 1};
    tbl[6] = '{1'b0, 8'h80, 1'b1, 8'h7F, 1};
    tbl[7] = '{1'b1, 8'h0F, 1'b0, 8'h00, 4};

    repeat (2) @(posedge clk);
    #1 req0 = 1'b1;
    @(negedge clk);
    chk("rst_gnt_blocked", int'(gnt0), 0);
    @(posedge clk); #1;
    req0 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_vals", int'({gnt0, gnt1, w_out, det_rst, done, done_id}), 0);
    chk("rst_hit", int'(hit_cnt), 0);

    foreach (tbl[i])
      run_word(tbl[i].id, tbl[i].d, tbl[i].chg, tbl[i].alt, tbl[i].hit);
    wait_idle();

    // contention: pointer freshly reset, so 0 wins first
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    data0 = 8'hFF; data1 = 8'h00;
    n = 0; last = 0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        chk("cont_order", int'(gnt1), n % 2);
        if (n > 0) chk("cont_gap", c - last, 12);
        last = c;
        n++;
      end
      @(posedge clk); #1;
    end
    chk("cont_grants", n, 4);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    // request arriving while busy waits for IDLE
    @(posedge clk); #1;
    req0 = 1'b1; data0 = 8'h3C;
    @(negedge clk);
    chk("busy_gnt0", int'(gnt0), 1);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) req0 = 1'b0;
      if (c == 4) begin req1 = 1'b1; data1 = 8'h55; end
      @(negedge clk);
      if (c >= 4 && c < 12) chk("busy_nognt1", int'(gnt1), 0);
      if (c == 11) chk("busy_done", int'(done), 1);
      if (c == 12) chk("busy_gnt1", int'(gnt1), 1);
    end
    @(posedge clk); #1;
    req1 = 1'b0;
    wait_idle();

    // reset in shift cycle 4 aborts the word
    @(posedge clk); #1;
    req0 = 1'b1; data0 = 8'hFF;
    @(negedge clk);
    chk("mid_gnt0", int'(gnt0), 1);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 1) req0 = 1'b0;
      if (c == 6) reset = 1'b1;
      if (c == 7) reset = 1'b0;
      @(negedge clk);
      if (c == 6) chk("mid_bit", int'(w_out), 1);
    end
    chk("mid_outs", int'({gnt0, gnt1, w_out, det_rst, done, done_id}), 0);
    chk("mid_hit", int'(hit_cnt), 0);
    nd = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_nodone", nd, 0);
    run_word(1'b1, 8'h0F, 1'b0, 8'h00, 4);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stream_sched.md
STREAM_SCHED -- requirements
Module: stream_sched

Interface
REQ-001 Parameter WIDTH, default 8, bits per serialized word (>=2).
REQ-002 Parameter CNTW, default 4, hit counter width; SHALL equal clog2(WIDTH+1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 has a word pending; held until gnt0.
REQ-006 data0  input  WIDTH  requester 0 word; valid while req0=1.
REQ-007 req1  input  1  requester 1 has a word pending; held until gnt1.
REQ-008 data1  input  WIDTH  requester 1 word; valid while req1=1.
REQ-009 gnt0  output  1  one-cycle accept pulse for requester 0.
REQ-010 gnt1  output  1  one-cycle accept pulse for requester 1.
REQ-011 w_out  output  1  serial bit to the pattern detector, MSB first.
REQ-012 det_rst  output  1  one-cycle clear pulse to the detector before each word.
REQ-013 det_in  input  1  registered detector output; reflects w_out of the previous cycle.
REQ-014 done  output  1  one-cycle pulse: word finished, hit_cnt/done_id valid.
REQ-015 done_id  output  1  requester index of the finished word.
REQ-016 hit_cnt  output  CNTW  number of det_in=1 samples for the finished word.

Function
REQ-017 FSM states IDLE, CLR, SHIFT, FLUSH, REPORT; the block serves one word at a time.
REQ-018 IDLE: if any req, grant one (gnt pulse in the same cycle), capture its data, and go to CLR; if none, stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: if both request, grant the one not granted last; after reset, requester 0 has priority.
REQ-020 Requests SHALL be ignored outside IDLE; gnt0 and gnt1 SHALL never be high together.
REQ-021 CLR: det_rst=1, w_out=0, for exactly one cycle, then go to SHIFT.
REQ-022 SHIFT lasts exactly WIDTH cycles; in SHIFT cycle k, w_out = captured word bit [WIDTH-1-k].
REQ-023 det_in SHALL be sampled in SHIFT cycles 1..WIDTH-1 and in the single FLUSH cycle (WIDTH samples); each 1 increments the counter.
REQ-024 The counter clears on entry to CLR; no saturation needed (max WIDTH fits CNTW).
REQ-025 FLUSH: w_out=0; next state REPORT.
REQ-026 REPORT: done=1 for one cycle, hit_cnt and done_id updated; next state IDLE.
REQ-027 hit_cnt and done_id SHALL hold their values until the next REPORT.
REQ-028 Latency: accept at cycle 0 gives done at cycle WIDTH+3; a new grant is possible in cycle WIDTH+4.
REQ-029 A request dropped before its grant is lost; data changing after its grant SHALL not affect the word in flight.

Reset
REQ-030 Reset SHALL force IDLE from any state, including mid-word, with no done pulse for the aborted word.
REQ-031 Reset values: gnt0=gnt1=0, w_out=0, det_rst=0, done=0, done_id=0, hit_cnt=0, round-robin pointer set so requester 0 wins.

Structure
REQ-032 State encodings and WIDTH/CNTW defaults SHALL live in shared package stream_sched_pkg.
REQ-033 Arbitration SHALL be a sub-module rr_arb2 (req0, req1, enable, pointer -> gnt0, gnt1); the FSM, shift register and counter stay in stream_sched.

Verification
REQ-034 The bench SHALL model det_in as w_out delayed by one register, so that expected hit_cnt = popcount(word).
REQ-035 Single word: req0 with data0=8'hB5 -> gnt0 at cycle 0; det_rst at cycle 1; w_out=1,0,1,1,0,1,0,1 in cycles 2-9; done at cycle 11 with hit_cnt=5 and done_id=0.
REQ-036 Contention: req0 and req1 held, data0=8'hFF, data1=8'h00 -> grant order 0,1,0,1; done results alternate hit_cnt=8/id0 and hit_cnt=0/id1; 12 cycles between grants.
REQ-037 Busy request: req1 asserted during SHIFT of word 0 -> no gnt1 until IDLE; gnt1 in the cycle after done.
REQ-038 Reset mid-word: reset in SHIFT cycle 4 -> next cycle in IDLE with all outputs 0 and no done; a following req1 (data1=8'h0F) completes with hit_cnt=4.
REQ-039 Data stability: data0 changed to 8'h00 after gnt0 for captured word 8'h81 -> hit_cnt=2.
